iob_eth_rx_dma: RTL and testbench
=================================

// Module: iob_eth_rx_dma
// PURPOSE
//  IOb-native bus master that drains received frames from the Ethernet core's CPU register interface.
//  - Polls ETH_STATUS until rx_data_rcvd is set.
//  - Reads ETH_DATA_RD word by word and emits the frame as a 32-bit AXI-Stream.
//  - Writes ETH_RCVACK to release the RX buffer.
//  Sits between the eth core's iob slave port and a stream consumer (packet parser / FIFO), replacing firmware polling.
// PARAMETERS
//  DATA_W        32     bus/stream data width (fixed 32)
//  ADDR_W        12     iob address width
//  STATUS_ADDR   0      byte address of ETH_STATUS
//  RCVACK_ADDR   8      byte address of ETH_RCVACK
//  DATA_RD_ADDR  2048   byte base address of ETH_DATA_RD window
//  POLL_DLY      16     idle cycles between consecutive status reads (>=1)
// PORTS
//  clk          in   1       system clock
//  rst          in   1       reset, asynchronous, active-high
//  en           in   1       enable draining; sampled in IDLE only
//  iob_avalid   out  1       request valid
//  iob_addr     out  ADDR_W  request byte address
//  iob_wdata    out  32      write data
//  iob_wstrb    out  4       write strobes (0 = read)
//  iob_ready    in   1       request accepted when avalid&ready
//  iob_rvalid   in   1       read data valid
//  iob_rdata    in   32      read data
//  m_tdata      out  32      frame word, byte0 in [7:0]
//  m_tkeep      out  4       valid bytes; all-ones except possibly last word
//  m_tlast      out  1       last word of frame
//  m_tvalid     out  1       stream valid
//  m_tready     in   1       stream ready
//  busy         out  1       high outside IDLE
//  frame_cnt    out  16      frames acknowledged, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; poll counter=0; any in-flight transaction abandoned.
//  Bus rules:
//   - One outstanding request.
//   - avalid/addr/wdata/wstrb held stable until ready.
//   - Read data arrives on rvalid >=1 cycle after acceptance; rvalid in the accept cycle is ignored.
//   - Writes complete at acceptance.
//  Status decode: rcvd=rdata[1]; N=rdata[14:4] (frame bytes, 0..2047).
//  FSM:
//   IDLE:  if en -> POLL_DLY.
//   POLL_DLY: count POLL_DLY cycles -> PREQ.
//   PREQ:  read STATUS_ADDR; on accept -> PWAIT.
//   PWAIT: on rvalid:
//    - rcvd=0 -> IDLE.
//    - rcvd=1, N=0 -> AREQ.
//    - else latch N, word idx=0 -> RREQ.
//   RREQ:  read DATA_RD_ADDR+4*idx; on accept -> RWAIT.
//   RWAIT: on rvalid: m_tdata<=rdata, m_tvalid<=1 -> OUT.
//   OUT:   hold word until m_tready.
//    - idx=ceil(N/4)-1 -> AREQ.
//    - else idx++ -> RREQ.
//   AREQ:  write RCVACK_ADDR, wdata=1, wstrb=4'hF; on accept -> frame_cnt++, IDLE.
//  Stream:
//   - m_tlast=1 only on word ceil(N/4)-1.
//   - m_tkeep on last word = N[1:0]==0 ? 4'hF : (1<<N[1:0])-1.
//   - tvalid never drops before handshake; tdata/tkeep/tlast stable while tvalid&!tready.
//   - m_tvalid rises the cycle after rvalid; next read issued the cycle after the tready handshake.
//  en deasserted mid-frame: frame completes incl. ack; then IDLE.
//  Backpressure: bus idle while OUT stalls; no word dropped or duplicated.
//  iob_rvalid without outstanding read: ignored.
//  Throughput: min 3 cycles/word with zero-wait bus and tready=1.
// TESTING
//  1. Status=0x0000_0402 (rcvd=1, N=64) -> 16 reads at 2048..2108, 16 beats, tlast on 16th, tkeep=F, then write 1 @8, frame_cnt=1.
//  2. N=61 -> 16 beats, last tkeep=4'b0001; N=62 -> 4'b0011.
//  3. Status rcvd=0 repeatedly -> only status reads, each >=POLL_DLY+1 cycles apart, m_tvalid stays 0.
//  4. rcvd=1, N=0 -> no stream beats; ack write issued directly.
//  5. Random m_tready and iob_ready/rvalid stalls on 2047-byte frame -> 512 beats match bus data in order; last tkeep=4'b0111.
//  6. rst pulse during RWAIT of word 5 -> outputs 0 next edge; after release, fresh status poll; frame_cnt=0.

Source files
------------

// File: rtl/iob_eth_rx_dma.sv
// IOb bus master that polls the Ethernet core for received frames, streams
// each frame out as 32-bit AXI-Stream words and acknowledges the RX buffer.
module iob_eth_rx_dma #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 12,
   parameter int STATUS_ADDR  = 0,
   parameter int RCVACK_ADDR  = 8,
   parameter int DATA_RD_ADDR = 2048,
   parameter int POLL_DLY     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   output logic              iob_avalid,
   output logic [ADDR_W-1:0] iob_addr,
   output logic [DATA_W-1:0] iob_wdata,
   output logic [3:0]        iob_wstrb,
   input  logic              iob_ready,
   input  logic              iob_rvalid,
   input  logic [DATA_W-1:0] iob_rdata,
   output logic [DATA_W-1:0] m_tdata,
   output logic [3:0]        m_tkeep,
   output logic              m_tlast,
   output logic              m_tvalid,
   input  logic              m_tready,
   output logic              busy,
   output logic [15:0]       frame_cnt
);

   localparam int CNT_W = $clog2(POLL_DLY + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_DLY, S_PREQ, S_PWAIT, S_RREQ, S_RWAIT, S_OUT, S_AREQ
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] dly_cnt;
   logic [8:0]       idx, last_idx;
   logic [1:0]       nb_mod;
   logic [10:0]      st_n;
   logic             st_rcvd, word_last;
   logic [3:0]       keep_last;

   assign st_rcvd   = iob_rdata[1];
   assign st_n      = iob_rdata[14:4];
   assign word_last = (idx == last_idx);
   assign busy      = (state != S_IDLE);

   // Partial-word byte mask; only the final word of a frame may be short.
   always_comb begin
      keep_last = 4'hF;
      if (word_last) begin
         case (nb_mod)
            2'd1:    keep_last = 4'h1;
            2'd2:    keep_last = 4'h3;
            2'd3:    keep_last = 4'h7;
            default: keep_last = 4'hF;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      iob_avalid = 1'b0;
      iob_addr   = '0;
      iob_wdata  = '0;
      iob_wstrb  = 4'h0;
      case (state)
         S_IDLE:  if (en) state_nxt = S_DLY;
         S_DLY:   if (dly_cnt == CNT_W'(POLL_DLY - 1)) state_nxt = S_PREQ;
         S_PREQ: begin
            iob_avalid = 1'b1;
            iob_addr   = ADDR_W'(STATUS_ADDR);
            if (iob_ready) state_nxt = S_PWAIT;
         end
         S_PWAIT: begin
            if (iob_rvalid) begin
               if (!st_rcvd)          state_nxt = S_IDLE;
               else if (st_n == '0)   state_nxt = S_AREQ;
               else                   state_nxt = S_RREQ;
            end
         end
         S_RREQ: begin
            iob_avalid = 1'b1;
            iob_addr   = ADDR_W'(DATA_RD_ADDR) + ADDR_W'({idx, 2'b00});
            if (iob_ready) state_nxt = S_RWAIT;
         end
         S_RWAIT: if (iob_rvalid) state_nxt = S_OUT;
         S_OUT:   if (m_tready) state_nxt = word_last ? S_AREQ : S_RREQ;
         S_AREQ: begin
            iob_avalid = 1'b1;
            iob_addr   = ADDR_W'(RCVACK_ADDR);
            iob_wdata  = DATA_W'(1);
            iob_wstrb  = 4'hF;
            if (iob_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dly_cnt   <= '0;
         idx       <= '0;
         last_idx  <= '0;
         nb_mod    <= '0;
         m_tdata   <= '0;
         m_tkeep   <= '0;
         m_tlast   <= 1'b0;
         m_tvalid  <= 1'b0;
         frame_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: dly_cnt <= '0;
            S_DLY:  dly_cnt <= dly_cnt + 1'b1;
            S_PWAIT: begin
               // Index of the final word is (N-1)/4; N=0 never reaches the data phase.
               if (iob_rvalid && st_rcvd && st_n != '0) begin
                  idx      <= '0;
                  last_idx <= 9'((st_n - 11'd1) >> 2);
                  nb_mod   <= st_n[1:0];
               end
            end
            S_RWAIT: begin
               if (iob_rvalid) begin
                  m_tdata  <= iob_rdata;
                  m_tkeep  <= keep_last;
                  m_tlast  <= word_last;
                  m_tvalid <= 1'b1;
               end
            end
            S_OUT: begin
               if (m_tready) begin
                  m_tvalid <= 1'b0;
                  if (!word_last) idx <= idx + 1'b1;
               end
            end
            S_AREQ: if (iob_ready) frame_cnt <= frame_cnt + 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_iob_eth_rx_dma.sv
// Scoreboard bench: a bus-slave model serves status/data reads, a stream
// monitor checks every beat against the expected queue built at frame setup.
module tb_iob_eth_rx_dma;
   localparam int POLL_DLY = 16;

   logic        clk = 1'b0, rst = 1'b1, en = 1'b0;
   logic        iob_avalid, iob_ready, iob_rvalid;
   logic [11:0] iob_addr;
   logic [31:0] iob_wdata, iob_rdata;
   logic [3:0]  iob_wstrb;
   logic [31:0] m_tdata;
   logic [3:0]  m_tkeep;
   logic        m_tlast, m_tvalid, m_tready, busy;
   logic [15:0] frame_cnt;

   iob_eth_rx_dma #(.POLL_DLY(POLL_DLY)) dut (
      .clk(clk), .rst(rst), .en(en),
      .iob_avalid(iob_avalid), .iob_addr(iob_addr), .iob_wdata(iob_wdata),
      .iob_wstrb(iob_wstrb), .iob_ready(iob_ready), .iob_rvalid(iob_rvalid),
      .iob_rdata(iob_rdata), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
      .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
      .busy(busy), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {logic [11:0] addr; logic [3:0] wstrb; logic [31:0] wdata;} bus_t;
   typedef struct packed {logic [31:0] data; logic [3:0] keep; logic last;} beat_t;

   bus_t        exp_bus[$];
   beat_t       exp_beat[$];
   logic [31:0] status_q[$];
   logic [31:0] mem[512];

   int n_tests = 0, n_fail = 0;
   int cyc = 0, last_stat = -1, stat_reads = 0, beats_seen = 0;
   int last_rd_idx = -1, pend_idx = -1, hold_idx = -1;
   bit stall_mode = 0, first_after_rst = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic load_frame(input int n, input bit rnd);
      int nw;
      beat_t b;
      nw = (n + 3) / 4;
      status_q.push_back((32'(n) << 4) | 32'h2);
      for (int i = 0; i < nw; i++) begin
         mem[i] = rnd ? $urandom : (32'hD000_0000 | (32'(n) << 12) | 32'(i));
         exp_bus.push_back('{addr: 12'(2048 + 4 * i), wstrb: 4'h0, wdata: 32'h0});
         b.data = mem[i];
         b.last = (i == nw - 1);
         b.keep = (b.last && (n % 4) != 0) ? 4'((1 << (n % 4)) - 1) : 4'hF;
         exp_beat.push_back(b);
      end
      exp_bus.push_back('{addr: 12'd8, wstrb: 4'hF, wdata: 32'h1});
   endtask

   task automatic wait_frames(input int target);
      for (int k = 0; k < 20000 && frame_cnt != 16'(target); k++) @(negedge clk);
      check("frame_cnt", frame_cnt, target);
      check("beats_drained", exp_beat.size(), 0);
      check("bus_ops_drained", exp_bus.size(), 0);
   endtask

   // Bus slave: decides ready/rvalid at the falling edge for the next rising edge.
   initial begin
      bus_t op, e;
      logic pend;
      logic [31:0] pend_data;
      int dly;
      iob_ready = 0; iob_rvalid = 0; iob_rdata = 0; pend = 0; dly = 0; pend_data = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            pend = 0; iob_ready = 0; iob_rvalid = 0;
            last_stat = -1; last_rd_idx = -1; pend_idx = -1;
         end else begin
            iob_rvalid = 0;
            if (pend) begin
               if (dly > 0) dly--;
               else if (!(pend_idx >= 0 && pend_idx == hold_idx)) begin
                  iob_rvalid = 1; iob_rdata = pend_data; pend = 0;
               end
            end else if (stall_mode && $urandom_range(7) == 0) begin
               iob_rvalid = 1; iob_rdata = $urandom;
            end
            iob_ready = 0;
            if (iob_avalid && (!stall_mode || $urandom_range(2) != 0)) begin
               iob_ready = 1;
               op = '{addr: iob_addr, wstrb: iob_wstrb, wdata: iob_wdata};
               if (first_after_rst) begin
                  check("first_req_after_rst", op.addr, 0);
                  first_after_rst = 0;
               end
               if (op.addr == 12'd0 && op.wstrb == 4'h0) begin
                  stat_reads++;
                  if (last_stat >= 0) check("poll_gap_ok", (cyc - last_stat) >= POLL_DLY + 1, 1);
                  last_stat = cyc;
                  pend = 1; pend_idx = -1;
                  pend_data = (status_q.size() != 0) ? status_q.pop_front() : 32'h0;
               end else if (exp_bus.size() == 0) begin
                  n_tests++; n_fail++;
                  $display("FAIL unexpected_req: got %0h expected none", op);
               end else begin
                  e = exp_bus.pop_front();
                  check("bus_req", op, e);
                  if (op.wstrb == 4'h0) begin
                     pend = 1;
                     pend_idx = (int'(op.addr) - 2048) / 4;
                     last_rd_idx = pend_idx;
                     pend_data = (pend_idx >= 0 && pend_idx < 512) ? mem[pend_idx] : 32'h0;
                  end
               end
               dly = stall_mode ? $urandom_range(3) : 0;
            end
         end
      end
   end

   // Stream monitor: drives tready, checks hold-while-stalled and each beat.
   initial begin
      beat_t cur, held, eb;
      bit stalled;
      m_tready = 0; stalled = 0; held = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            m_tready = 0; stalled = 0;
         end else begin
            cur = '{data: m_tdata, keep: m_tkeep, last: m_tlast};
            if (stalled) begin
               check("tvalid_hold", m_tvalid, 1);
               check("tdata_hold", cur, held);
            end
            m_tready = stall_mode ? ($urandom_range(2) != 0) : 1'b1;
            if (m_tvalid && m_tready) begin
               beats_seen++;
               if (exp_beat.size() == 0) begin
                  n_tests++; n_fail++;
                  $display("FAIL unexpected_beat: got %0h expected none", cur);
               end else begin
                  eb = exp_beat.pop_front();
                  check("beat", cur, eb);
               end
            end
            stalled = m_tvalid && !m_tready;
            held = cur;
         end
      end
   end

   initial begin
      int snap;
      repeat (3) @(negedge clk);
      check("rst_avalid", iob_avalid, 0);
      check("rst_tvalid", m_tvalid, 0);
      check("rst_busy", busy, 0);
      check("rst_frame_cnt", frame_cnt, 0);
      check("rst_stream", {m_tdata, m_tkeep, m_tlast}, 0);
      rst = 0;
      en  = 1;

      // 64-byte frame: status 0x402
      load_frame(64, 0);
      wait_frames(1);

      // short last words
      load_frame(61, 0);
      wait_frames(2);
      load_frame(62, 0);
      wait_frames(3);

      // idle polls then an empty frame
      snap = beats_seen;
      repeat (3) status_q.push_back(32'h0);
      load_frame(0, 0);
      wait_frames(4);
      check("no_beats_empty", beats_seen, snap);

      // en dropped mid-frame: frame still completes, then stays idle
      load_frame(24, 0);
      for (int k = 0; k < 2000 && exp_beat.size() > 4; k++) @(negedge clk);
      en = 0;
      wait_frames(5);
      snap = stat_reads;
      repeat (40) @(negedge clk);
      check("idle_after_en_low", busy, 0);
      check("no_poll_en_low", stat_reads, snap);
      en = 1;

      // max frame with random stalls everywhere
      stall_mode = 1;
      load_frame(2047, 1);
      wait_frames(6);
      stall_mode = 0;

      // reset while waiting on word 5
      hold_idx = 5;
      load_frame(32, 0);
      for (int k = 0; k < 5000 && last_rd_idx != 5; k++) @(negedge clk);
      check("reached_word5", last_rd_idx, 5);
      @(negedge clk);
      #2 rst = 1;
      @(posedge clk);
      #1;
      check("rst6_avalid", iob_avalid, 0);
      check("rst6_tvalid", m_tvalid, 0);
      check("rst6_busy", busy, 0);
      check("rst6_frame_cnt", frame_cnt, 0);
      check("rst6_stream", {m_tdata, m_tkeep, m_tlast}, 0);
      exp_bus.delete();
      exp_beat.delete();
      status_q.delete();
      hold_idx = -1;
      @(negedge clk);
      #2 rst = 0;
      first_after_rst = 1;
      load_frame(8, 0);
      wait_frames(1);
      check("first_req_seen", first_after_rst, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
